// File: rtl/small_div_pkg.sv
// Shared elaboration helpers for small_div: stage geometry and the per-stage
// long-division lookup-table contents.
package small_div_pkg;

    function automatic int chunk_width(input int lut_width, input int rem_width);
        return lut_width - rem_width;
    endfunction

    function automatic int stage_count(input int dividend_width, input int chunk);
        if (chunk < 1) begin
            return 1;
        end
        return (dividend_width + chunk - 1) / chunk;
    endfunction

    // LUT address is {r_in, chunk}, so the partial dividend v equals the address.
    function automatic logic [31:0] lut_entry(input int d, input int chunk, input int addr);
        int w;
        int q;
        int r;
        w = $clog2(d);
        if ((addr >> chunk) >= d) begin
            return 32'd0;
        end
        q = addr / d;
        r = addr % d;
        return (q << w) | r;
    endfunction

endpackage

// File: rtl/small_div_stage.sv
// One radix-2^C long-division step: a constant LUT maps {remainder, chunk} to
// {digit, remainder}; quotient and unconsumed dividend fields shift alongside.
module small_div_stage
    import small_div_pkg::*;
#(
    parameter int D   = 5,
    parameter int W   = 3,
    parameter int C   = 3,
    parameter int SC  = 18,
    parameter int REG = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic [W-1:0]  rem_in,
    input  logic [SC-1:0] quo_in,
    input  logic [SC-1:0] div_in,
    output logic [W-1:0]  rem_out,
    output logic [SC-1:0] quo_out,
    output logic [SC-1:0] div_out
);

    localparam int L = C + W;

    logic [L-1:0]  rom [2**L];
    logic [L-1:0]  addr;
    logic [L-1:0]  entry;
    logic [W-1:0]  rem_next;
    logic [SC-1:0] quo_next;
    logic [SC-1:0] div_next;

    for (genvar gi = 0; gi < 2**L; gi++) begin : g_rom
        localparam logic [31:0] ENTRY = lut_entry(D, C, gi);
        assign rom[gi] = ENTRY[L-1:0];
    end

    assign addr  = {rem_in, div_in[SC-1 -: C]};
    assign entry = rom[addr];

    always_comb begin
        rem_next           = entry[W-1:0];
        quo_next           = quo_in << C;
        quo_next[C-1:0]    = entry[L-1:W];
        div_next           = div_in << C;
    end

    if (REG != 0) begin : g_reg
        logic [W-1:0]  rem_reg;
        logic [SC-1:0] quo_reg;
        logic [SC-1:0] div_reg;

        always_ff @(posedge clock) begin
            if (reset) begin
                rem_reg <= '0;
                quo_reg <= '0;
                div_reg <= '0;
            end else if (enable) begin
                rem_reg <= rem_next;
                quo_reg <= quo_next;
                div_reg <= div_next;
            end
        end

        assign rem_out = rem_reg;
        assign quo_out = quo_reg;
        assign div_out = div_reg;
    end else begin : g_comb
        assign rem_out = rem_next;
        assign quo_out = quo_next;
        assign div_out = div_next;
    end

endmodule

// File: rtl/small_div.sv
// Pipelined division by a small constant, built from a chain of LUT stages
// with optional input, inter-stage and output registers.
module small_div
    import small_div_pkg::*;
#(
    parameter int DIVIDER_VALUE         = 5,
    parameter int DIVIDER_WIDTH         = $clog2(DIVIDER_VALUE),
    parameter int DIVIDEND_WIDTH        = 18,
    parameter int THEORETICAL_LUT_WIDTH = 6,
    parameter int REGISTER_IN           = 0,
    parameter int REGISTER_OUT          = 1,
    parameter int PIPELINE              = 1
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    enable,
    input  logic [DIVIDEND_WIDTH-1:0]               dividend,
    output logic [DIVIDEND_WIDTH-DIVIDER_WIDTH-1:0] quotient,
    output logic [DIVIDER_WIDTH-1:0]                remainder
);

    localparam int N  = DIVIDEND_WIDTH;
    localparam int W  = DIVIDER_WIDTH;
    localparam int C  = chunk_width(THEORETICAL_LUT_WIDTH, W);
    localparam int S  = stage_count(N, C);
    localparam int SC = S * C;
    localparam int QW = N - W;

    if (C < 1) begin : g_bad_chunk
        $error("small_div: LUT width must exceed remainder width");
    end
    if (DIVIDER_VALUE < 2) begin : g_bad_divider
        $error("small_div: divider must be at least 2");
    end

    logic [N-1:0]  din;
    logic [SC-1:0] div_ext;
    logic [W-1:0]  rem_s [S+1];
    logic [SC-1:0] quo_s [S+1];
    logic [SC-1:0] div_s [S+1];

    if (REGISTER_IN != 0) begin : g_in_reg
        logic [N-1:0] din_reg;
        always_ff @(posedge clock) begin
            if (reset) begin
                din_reg <= '0;
            end else if (enable) begin
                din_reg <= dividend;
            end
        end
        assign din = din_reg;
    end else begin : g_in_comb
        assign din = dividend;
    end

    // Zero-extend on the MSB side so the dividend splits into whole chunks.
    always_comb begin
        div_ext        = '0;
        div_ext[N-1:0] = din;
    end

    assign rem_s[0] = '0;
    assign quo_s[0] = '0;
    assign div_s[0] = div_ext;

    for (genvar gi = 0; gi < S; gi++) begin : g_stage
        small_div_stage #(
            .D   (DIVIDER_VALUE),
            .W   (W),
            .C   (C),
            .SC  (SC),
            .REG ((PIPELINE != 0 && gi < S - 1) ? 1 : 0)
        ) u_stage (
            .clock   (clock),
            .reset   (reset),
            .enable  (enable),
            .rem_in  (rem_s[gi]),
            .quo_in  (quo_s[gi]),
            .div_in  (div_s[gi]),
            .rem_out (rem_s[gi+1]),
            .quo_out (quo_s[gi+1]),
            .div_out (div_s[gi+1])
        );
    end

    // The fully consumed dividend field and quotient bits above QW are dropped.
    logic unused_bits;
    assign unused_bits = ^{div_s[S], quo_s[S][SC-1:QW]};

    if (REGISTER_OUT != 0) begin : g_out_reg
        logic [QW-1:0] quo_reg;
        logic [W-1:0]  rem_reg;
        always_ff @(posedge clock) begin
            if (reset) begin
                quo_reg <= '0;
                rem_reg <= '0;
            end else if (enable) begin
                quo_reg <= quo_s[S][QW-1:0];
                rem_reg <= rem_s[S];
            end
        end
        assign quotient  = quo_reg;
        assign remainder = rem_reg;
    end else begin : g_out_comb
        assign quotient  = quo_s[S][QW-1:0];
        assign remainder = rem_s[S];
    end

endmodule

// File: tb/tb_small_div.sv
// Self-checking bench for small_div: default build plus three parameter
// variants, all checked against a plain / and % model with a delay line.
module tb_small_div;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;

    logic [17:0] dvd0, dvd3;
    logic [11:0] dvd1;
    logic [15:0] dvd2;
    logic [14:0] quo0, quo3;
    logic [9:0]  quo1;
    logic [12:0] quo2;
    logic [2:0]  rem0, rem2, rem3;
    logic [1:0]  rem1;

    int errors = 0;
    int checks = 0;

    int dv[4] = '{5, 3, 7, 5};
    int nv[4] = '{18, 12, 16, 18};
    int lv[4] = '{6, 4, 6, 6};
    int ri[4] = '{0, 0, 0, 1};
    int pl[4] = '{1, 1, 1, 0};
    int ro[4] = '{1, 1, 1, 0};
    int wv[4];
    int lat[4];

    int unsigned din[4];
    int unsigned line[4][8];
    int unsigned q_obs[4];
    int unsigned r_obs[4];

    always #5 clock = ~clock;

    small_div #(
        .DIVIDER_VALUE(5), .DIVIDEND_WIDTH(18), .THEORETICAL_LUT_WIDTH(6)
    ) dut0 (
        .clock(clock), .reset(reset), .enable(enable),
        .dividend(dvd0), .quotient(quo0), .remainder(rem0)
    );

    small_div #(
        .DIVIDER_VALUE(3), .DIVIDEND_WIDTH(12), .THEORETICAL_LUT_WIDTH(4)
    ) dut1 (
        .clock(clock), .reset(reset), .enable(enable),
        .dividend(dvd1), .quotient(quo1), .remainder(rem1)
    );

    small_div #(
        .DIVIDER_VALUE(7), .DIVIDEND_WIDTH(16), .THEORETICAL_LUT_WIDTH(6)
    ) dut2 (
        .clock(clock), .reset(reset), .enable(enable),
        .dividend(dvd2), .quotient(quo2), .remainder(rem2)
    );

    small_div #(
        .DIVIDER_VALUE(5), .DIVIDEND_WIDTH(18), .THEORETICAL_LUT_WIDTH(6),
        .REGISTER_IN(1), .PIPELINE(0), .REGISTER_OUT(0)
    ) dut3 (
        .clock(clock), .reset(reset), .enable(enable),
        .dividend(dvd3), .quotient(quo3), .remainder(rem3)
    );

    always_comb begin
        q_obs[0] = 32'(quo0);
        q_obs[1] = 32'(quo1);
        q_obs[2] = 32'(quo2);
        q_obs[3] = 32'(quo3);
        r_obs[0] = 32'(rem0);
        r_obs[1] = 32'(rem1);
        r_obs[2] = 32'(rem2);
        r_obs[3] = 32'(rem3);
    end

    function automatic int unsigned exp_quo(input int i, input int unsigned x);
        return (x / dv[i]) % (32'd1 << (nv[i] - wv[i]));
    endfunction

    function automatic int unsigned exp_rem(input int i, input int unsigned x);
        return x % dv[i];
    endfunction

    // Drive one clock edge; the model records what each DUT samples at that edge.
    task automatic step(input bit en, input bit rst);
        for (int i = 1; i < 4; i++) din[i] = $urandom;
        enable = en;
        reset  = rst;
        dvd0 = din[0][17:0];
        dvd1 = din[1][11:0];
        dvd2 = din[2][15:0];
        dvd3 = din[3][17:0];
        @(posedge clock);
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                for (int k = 0; k < 8; k++) line[i][k] = 0;
            end else if (en) begin
                for (int k = 7; k > 0; k--) line[i][k] = line[i][k-1];
                line[i][0] = din[i] & ((32'd1 << nv[i]) - 1);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        din[0] = 0;
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (q_obs[i] !== 0 || r_obs[i] !== 0) begin
                errors++;
                $display("FAIL reset dut%0d: got q=%0d r=%0d, expected q=0 r=0", i, q_obs[i], r_obs[i]);
            end
        end
    endtask

    task automatic test_count_up(input int unsigned first, input int unsigned last);
        int unsigned x;
        for (int unsigned v = first; v <= last; v++) begin
            din[0] = v;
            step(1'b1, 1'b0);
            x = line[0][lat[0]-1];
            checks++;
            if (q_obs[0] !== exp_quo(0, x) || r_obs[0] !== exp_rem(0, x)) begin
                errors++;
                $display("FAIL count_up x=%0d: got q=%0d r=%0d, expected q=%0d r=%0d",
                         x, q_obs[0], r_obs[0], exp_quo(0, x), exp_rem(0, x));
            end
        end
    endtask

    task automatic test_boundary();
        int unsigned vals[4]  = '{99999, 163839, 163840, 262143};
        int unsigned eq_t[4]  = '{19999, 32767, 0, 19660};
        int unsigned er_t[4]  = '{4, 4, 0, 3};
        for (int k = 0; k < 4 + lat[0]; k++) begin
            din[0] = (k < 4) ? vals[k] : 0;
            step(1'b1, 1'b0);
            if (k >= lat[0] - 1 && k - (lat[0] - 1) < 4) begin
                checks++;
                if (q_obs[0] !== eq_t[k-lat[0]+1] || r_obs[0] !== er_t[k-lat[0]+1]) begin
                    errors++;
                    $display("FAIL boundary x=%0d: got q=%0d r=%0d, expected q=%0d r=%0d",
                             vals[k-lat[0]+1], q_obs[0], r_obs[0],
                             eq_t[k-lat[0]+1], er_t[k-lat[0]+1]);
                end
            end
        end
    endtask

    task automatic test_enable_stall();
        int unsigned pq[4];
        int unsigned pr[4];
        int unsigned x;
        for (int k = 0; k < 10; k++) begin
            din[0] = $urandom_range(0, 163839);
            step(1'b1, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            pq[i] = q_obs[i];
            pr[i] = r_obs[i];
        end
        for (int k = 0; k < 3; k++) begin
            din[0] = $urandom_range(0, 163839);
            step(1'b0, 1'b0);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (q_obs[i] !== pq[i] || r_obs[i] !== pr[i]) begin
                    errors++;
                    $display("FAIL stall_hold dut%0d: got q=%0d r=%0d, expected q=%0d r=%0d",
                             i, q_obs[i], r_obs[i], pq[i], pr[i]);
                end
            end
        end
        for (int k = 0; k < 10; k++) begin
            din[0] = $urandom_range(0, 163839);
            step(1'b1, 1'b0);
            for (int i = 0; i < 4; i++) begin
                x = line[i][lat[i]-1];
                checks++;
                if (q_obs[i] !== exp_quo(i, x) || r_obs[i] !== exp_rem(i, x)) begin
                    errors++;
                    $display("FAIL stall_resume dut%0d x=%0d: got q=%0d r=%0d, expected q=%0d r=%0d",
                             i, x, q_obs[i], r_obs[i], exp_quo(i, x), exp_rem(i, x));
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        int unsigned first;
        for (int k = 0; k < 8; k++) begin
            din[0] = $urandom_range(5, 163839);
            step(1'b1, 1'b0);
        end
        din[0] = $urandom_range(5, 163839);
        step(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (q_obs[i] !== 0 || r_obs[i] !== 0) begin
                errors++;
                $display("FAIL midreset_clear dut%0d: got q=%0d r=%0d, expected q=0 r=0",
                         i, q_obs[i], r_obs[i]);
            end
        end
        first = $urandom_range(5, 163839);
        for (int j = 1; j <= lat[0]; j++) begin
            din[0] = (j == 1) ? first : $urandom_range(5, 163839);
            step(1'b1, 1'b0);
            checks++;
            if (j < lat[0]) begin
                if (q_obs[0] !== 0 || r_obs[0] !== 0) begin
                    errors++;
                    $display("FAIL midreset_flush step %0d: got q=%0d r=%0d, expected q=0 r=0",
                             j, q_obs[0], r_obs[0]);
                end
            end else if (q_obs[0] !== first / 5 || r_obs[0] !== first % 5) begin
                errors++;
                $display("FAIL midreset_first x=%0d: got q=%0d r=%0d, expected q=%0d r=%0d",
                         first, q_obs[0], r_obs[0], first / 5, first % 5);
            end
        end
    endtask

    task automatic test_param_sweep();
        int unsigned x;
        for (int k = 0; k < 3000; k++) begin
            din[0] = $urandom;
            step(($urandom_range(0, 9) != 0), 1'b0);
            for (int i = 0; i < 4; i++) begin
                x = line[i][lat[i]-1];
                checks++;
                if (q_obs[i] !== exp_quo(i, x) || r_obs[i] !== exp_rem(i, x)) begin
                    errors++;
                    $display("FAIL sweep dut%0d x=%0d: got q=%0d r=%0d, expected q=%0d r=%0d",
                             i, x, q_obs[i], r_obs[i], exp_quo(i, x), exp_rem(i, x));
                end
            end
        end
    endtask

    initial begin
        int c;
        int s;
        for (int i = 0; i < 4; i++) begin
            wv[i]  = $clog2(dv[i]);
            c      = lv[i] - wv[i];
            s      = (nv[i] + c - 1) / c;
            lat[i] = ri[i] + pl[i] * (s - 1) + ro[i];
            din[i] = 0;
        end
        test_reset();
        test_count_up(0, 19999);
        test_count_up(99990, 100005);
        test_boundary();
        test_enable_stall();
        test_reset_midstream();
        test_param_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
